usb2_packet_rx: RTL and testbench
=================================

Name: usb2_packet_rx

Overview:
Receive-side USB 2.0 packet decoder, directly downstream of the ULPI link block, in the 60 MHz phy_clk domain. Consumes the link's raw byte stream (active, byte, latch). Validates the PID and classifies each packet as token, data, handshake or other. Checks CRC5 on tokens and CRC16 on data, strips PID and CRC bytes, and presents decoded fields and payload to the protocol/endpoint layer.

Parameters:
MAX_DATA, 1024, maximum data payload bytes (excluding PID/CRC) before a length error.

Ports:
phy_clk  in  1  60 MHz ULPI clock; all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
in_act  in  1  receive active (link pkt_out_act); a packet spans one contiguous high period.
in_byte  in  8  received byte, valid only when in_latch=1.
in_latch  in  1  one byte strobe; only counted while in_act=1.
tok_valid  out  1  one-cycle pulse: good token decoded.
tok_pid  out  4  token PID (OUT/IN/SOF/SETUP/PING).
tok_addr  out  7  device address (non-SOF).
tok_endp  out  4  endpoint (non-SOF).
tok_frame  out  11  frame number (SOF only).
hs_valid  out  1  one-cycle pulse: good handshake.
hs_pid  out  4  handshake PID (ACK/NAK/STALL/NYET).
dat_start  out  1  one-cycle pulse: data packet began.
dat_pid  out  4  DATA0/1/2/MDATA; stable from dat_start to dat_end.
dat_valid  out  1  payload byte strobe.
dat_byte  out  8  payload byte.
dat_end  out  1  one-cycle pulse: data packet finished.
dat_crc_ok  out  1  qualifies dat_end: CRC16 good and length legal.
dat_len  out  11  payload byte count; valid with dat_end.
err_pid  out  1  pulse: PID check failure.
err_crc  out  1  pulse: CRC5/CRC16 failure.
err_len  out  1  pulse: illegal byte count.

Behaviour:
- Reset (async assert, sync release): FSM to ST_IDLE; every output 0; CRC registers, counters and delay pipeline cleared. Reset mid-packet discards it; decoding resumes at the next in_act rising edge.
- All outputs registered. Pulses last exactly one cycle.
- States: ST_IDLE, ST_PID, ST_TOKEN, ST_DATA, ST_HS, ST_DISCARD, ST_END.
- ST_IDLE: on in_act=1, go to ST_PID.
- ST_PID: first latched byte is the PID.
  - If byte[7:4] != ~byte[3:0]: pulse err_pid, go to ST_DISCARD.
  - Class by PID[1:0]:
    - 01 (token) or 0100 (PING) -> ST_TOKEN.
    - 11 (data) -> ST_DATA; dat_start pulses and dat_pid is loaded in the cycle after the PID latch.
    - 10 (handshake) -> ST_HS.
    - Other 00 class (PRE/ERR/SPLIT, reserved) -> ST_DISCARD, no error.
  - in_act falling before any latch -> ST_IDLE silently.
- ST_TOKEN: capture exactly 2 bytes.
  - addr = b1[6:0]; endp = {b2[2:0], b1[7]}; frame = {b2[2:0], b1}.
  - CRC5: poly x^5+x^2+1, init 5'b11111, LSB-first over all 16 bits; good residual is 5'b01100.
- ST_DATA: CRC16: poly 0x8005, init 16'hFFFF, LSB-first over all bytes incl. CRC.
  - Good residual: 16'h800D (conventional order), equal to 16'hB001 in a right-shifting reflected register.
  - Two-byte delay pipeline so CRC bytes are never forwarded: payload byte n appears on dat_byte/dat_valid the cycle after byte n+2 is latched.
  - Payload count saturates at MAX_DATA+1. On exceeding MAX_DATA, dat_valid is suppressed for the rest of the packet.
- ST_HS: exactly 1 byte total (PID only) is legal.
- ST_DISCARD: ignore latches until in_act=0, then go to ST_IDLE.
- End of packet: first cycle with in_act=0 while in a receive state -> ST_END. Results appear the next cycle, then back to ST_IDLE.
  - Token: byte count !=2 -> err_len. Else bad CRC -> err_crc. Else tok_valid with fields.
  - Handshake: extra bytes -> err_len, no hs_valid.
  - Data: dat_end always pulses. dat_len = bytes after PID minus 2.
    - Fewer than 2 bytes after PID -> dat_len=0, err_len, dat_crc_ok=0.
    - Overflow -> err_len, dat_crc_ok=0, dat_len=MAX_DATA+1.
    - Bad CRC -> err_crc, dat_crc_ok=0.
    - Otherwise dat_crc_ok=1.
- Priority when both apply: err_len over err_crc; only one error pulse per packet.
- in_act re-rising in ST_END is accepted: the next packet's ST_PID follows directly, with no bytes lost.

Test Plan:
- SETUP token 2D 00 10 -> tok_valid=1 one cycle after in_act falls, tok_pid=D, tok_addr=0, tok_endp=0; no error pulses.
- Handshake D2 -> hs_valid, hs_pid=2. PID byte 2E -> err_pid; no other output for that packet.
- DATA0 C3 80 06 00 01 00 00 40 00 DD 94 -> dat_start, dat_pid=3, 8 dat_valid bytes 80 06 00 01 00 00 40 00 in order, dat_end, dat_crc_ok=1, dat_len=8. Same packet with last byte 95 -> dat_crc_ok=0, err_crc.
- Zero-length DATA1 4B 00 00 -> dat_start, no dat_valid, dat_end with dat_len=0, dat_crc_ok=1. Data packet 4B 00 -> err_len.
- Token 2D 00 (only 2 bytes total) -> err_len, no tok_valid. Token 2D 00 11 -> err_crc.
- Assert reset_n=0 midway through the 11-byte DATA0 -> all outputs 0 immediately. Then release and send D2 -> hs_valid only, no stale dat_end.

Source files
------------

// File: rtl/usb2_packet_rx.sv
// usb2_packet_rx
// Receive-side USB 2.0 packet decoder sitting behind the ULPI link block
// (phy_clk domain). Each contiguous in_act high period is one packet.
// The first latched byte is the PID, which is validated and classified.
// Tokens are CRC5 checked and split into address, endpoint and frame fields.
// Data payload is CRC16 checked and streamed out with the PID and CRC bytes
// removed. Handshakes are length checked.
//
// Ports
//   phy_clk, reset_n          clock, asynchronous active-low reset
//   in_act, in_byte, in_latch raw link byte stream
//   tok_*                     decoded token (tok_valid pulses once)
//   hs_*                      decoded handshake (hs_valid pulses once)
//   dat_*                     data packet start, payload stream, end status
//   err_pid/err_crc/err_len   one-cycle error pulses, at most one per packet
//   fsm_state                 current decoder state, for observation
//
// Handshake semantics: there is no back-pressure. A byte is consumed exactly
// when in_latch=1 and in_act=1. Every output is registered. The *_valid,
// *_start, *_end and err_* outputs are single-cycle pulses.
module usb2_packet_rx #(
   parameter int MAX_DATA = 1024
) (
   input  logic        phy_clk,
   input  logic        reset_n,
   input  logic        in_act,
   input  logic [7:0]  in_byte,
   input  logic        in_latch,
   output logic        tok_valid,
   output logic [3:0]  tok_pid,
   output logic [6:0]  tok_addr,
   output logic [3:0]  tok_endp,
   output logic [10:0] tok_frame,
   output logic        hs_valid,
   output logic [3:0]  hs_pid,
   output logic        dat_start,
   output logic [3:0]  dat_pid,
   output logic        dat_valid,
   output logic [7:0]  dat_byte,
   output logic        dat_end,
   output logic        dat_crc_ok,
   output logic [10:0] dat_len,
   output logic        err_pid,
   output logic        err_crc,
   output logic        err_len,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PID     = 3'd1,
      ST_TOKEN   = 3'd2,
      ST_DATA    = 3'd3,
      ST_HS      = 3'd4,
      ST_DISCARD = 3'd5,
      ST_END     = 3'd6
   } state_t;

   // The byte counter counts every byte after the PID, CRC bytes included.
   localparam logic [10:0] PAY_LIM = 11'(MAX_DATA + 2);
   localparam logic [10:0] CNT_SAT = 11'(MAX_DATA + 3);
   localparam logic [10:0] LEN_OVF = 11'(MAX_DATA + 1);

   state_t      state, state_nxt;
   logic        act_q;
   logic [10:0] cnt;
   logic [7:0]  d0, d1;
   logic [4:0]  crc5;
   logic [15:0] crc16;
   logic [3:0]  pid_q;
   logic        rx_state, pid_lat, body_lat, rx_end;

   function automatic state_t pid_class(input logic [7:0] b);
      state_t r;
      if (b[7:4] != ~b[3:0])                       r = ST_DISCARD;
      else if (b[1:0] == 2'b01 || b[3:0] == 4'b0100) r = ST_TOKEN;
      else if (b[1:0] == 2'b11)                    r = ST_DATA;
      else if (b[1:0] == 2'b10)                    r = ST_HS;
      else                                         r = ST_DISCARD;
      return r;
   endfunction

   // CRC5 in the conventional (left-shifting) register, bits taken LSB first.
   function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
      logic [4:0] r;
      logic       fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = b[i] ^ r[4];
         r  = {r[3:0], 1'b0};
         if (fb) r = r ^ 5'b00101;
      end
      return r;
   endfunction

   // CRC16 in the reflected (right-shifting) register; good residual is 16'hB001.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = b[i] ^ r[0];
         r  = {1'b0, r[15:1]};
         if (fb) r = r ^ 16'hA001;
      end
      return r;
   endfunction

   // A packet may only start on a genuine in_act rising edge. act_q resets
   // high so that a packet cut in half by reset is ignored until in_act drops.
   always_comb begin
      rx_state = (state == ST_TOKEN) || (state == ST_DATA) || (state == ST_HS);
      pid_lat  = in_act && in_latch &&
                 ((state == ST_PID) || (!act_q && (state == ST_IDLE || state == ST_END)));
      body_lat = in_act && in_latch && rx_state;
      rx_end   = !in_act && rx_state;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_END: begin
            state_nxt = ST_IDLE;
            if (in_act && !act_q) state_nxt = in_latch ? pid_class(in_byte) : ST_PID;
         end
         ST_PID: begin
            if (!in_act)       state_nxt = ST_IDLE;
            else if (in_latch) state_nxt = pid_class(in_byte);
         end
         ST_TOKEN, ST_DATA, ST_HS: begin
            if (!in_act) state_nxt = ST_END;
         end
         ST_DISCARD: begin
            if (!in_act) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         act_q <= 1'b1;
      end else begin
         state <= state_nxt;
         act_q <= in_act;
      end
   end

   assign fsm_state = state;

   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         d0         <= '0;
         d1         <= '0;
         crc5       <= '0;
         crc16      <= '0;
         pid_q      <= '0;
         tok_valid  <= 1'b0;
         tok_pid    <= '0;
         tok_addr   <= '0;
         tok_endp   <= '0;
         tok_frame  <= '0;
         hs_valid   <= 1'b0;
         hs_pid     <= '0;
         dat_start  <= 1'b0;
         dat_pid    <= '0;
         dat_valid  <= 1'b0;
         dat_byte   <= '0;
         dat_end    <= 1'b0;
         dat_crc_ok <= 1'b0;
         dat_len    <= '0;
         err_pid    <= 1'b0;
         err_crc    <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         tok_valid  <= 1'b0;
         hs_valid   <= 1'b0;
         dat_start  <= 1'b0;
         dat_valid  <= 1'b0;
         dat_end    <= 1'b0;
         dat_crc_ok <= 1'b0;
         err_pid    <= 1'b0;
         err_crc    <= 1'b0;
         err_len    <= 1'b0;

         if (pid_lat) begin
            cnt   <= '0;
            crc5  <= 5'b11111;
            crc16 <= 16'hFFFF;
            pid_q <= in_byte[3:0];
            if (in_byte[7:4] != ~in_byte[3:0]) begin
               err_pid <= 1'b1;
            end else if (pid_class(in_byte) == ST_DATA) begin
               dat_start <= 1'b1;
               dat_pid   <= in_byte[3:0];
            end
         end

         if (body_lat) begin
            if (cnt != CNT_SAT) cnt <= cnt + 11'd1;
            d0    <= in_byte;
            d1    <= d0;
            crc5  <= crc5_byte(crc5, in_byte);
            crc16 <= crc16_byte(crc16, in_byte);
            // d1 is two bytes behind the incoming one, so it can never be CRC.
            if (state == ST_DATA && cnt >= 11'd2 && cnt < PAY_LIM) begin
               dat_valid <= 1'b1;
               dat_byte  <= d1;
            end
         end

         if (rx_end) begin
            case (state)
               ST_TOKEN: begin
                  if (cnt != 11'd2)          err_len <= 1'b1;
                  else if (crc5 != 5'b01100) err_crc <= 1'b1;
                  else begin
                     tok_valid <= 1'b1;
                     tok_pid   <= pid_q;
                     tok_addr  <= d1[6:0];
                     tok_endp  <= {d0[2:0], d1[7]};
                     tok_frame <= {d0[2:0], d1};
                  end
               end
               ST_HS: begin
                  if (cnt != 11'd0) err_len <= 1'b1;
                  else begin
                     hs_valid <= 1'b1;
                     hs_pid   <= pid_q;
                  end
               end
               default: begin
                  dat_end <= 1'b1;
                  if (cnt < 11'd2) begin
                     err_len <= 1'b1;
                     dat_len <= '0;
                  end else if (cnt > PAY_LIM) begin
                     err_len <= 1'b1;
                     dat_len <= LEN_OVF;
                  end else begin
                     dat_len <= cnt - 11'd2;
                     if (crc16 != 16'hB001) err_crc    <= 1'b1;
                     else                   dat_crc_ok <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb2_packet_rx.sv
// tb_usb2_packet_rx
// Directed bench for usb2_packet_rx. A monitor counts every output pulse,
// captures decoded fields and checks payload bytes against exp_q. After each
// packet the driver compares the counts and fields with hand-computed values.
// MAX_DATA is set to 8 so that the length limit can be reached cheaply.
module tb_usb2_packet_rx;

   logic        phy_clk = 1'b0;
   logic        reset_n;
   logic        in_act, in_latch;
   logic [7:0]  in_byte;
   logic        tok_valid, hs_valid, dat_start, dat_valid, dat_end, dat_crc_ok;
   logic [3:0]  tok_pid, tok_endp, hs_pid, dat_pid;
   logic [6:0]  tok_addr;
   logic [10:0] tok_frame, dat_len;
   logic [7:0]  dat_byte;
   logic        err_pid, err_crc, err_len;
   logic [2:0]  fsm_state;

   usb2_packet_rx #(.MAX_DATA(8)) dut (
      .phy_clk(phy_clk), .reset_n(reset_n),
      .in_act(in_act), .in_byte(in_byte), .in_latch(in_latch),
      .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_addr(tok_addr),
      .tok_endp(tok_endp), .tok_frame(tok_frame),
      .hs_valid(hs_valid), .hs_pid(hs_pid),
      .dat_start(dat_start), .dat_pid(dat_pid), .dat_valid(dat_valid),
      .dat_byte(dat_byte), .dat_end(dat_end), .dat_crc_ok(dat_crc_ok),
      .dat_len(dat_len),
      .err_pid(err_pid), .err_crc(err_crc), .err_len(err_len),
      .fsm_state(fsm_state)
   );

   // clock / cycle counter
   always #5 phy_clk = ~phy_clk;

   int cyc = 0;
   always @(posedge phy_clk) cyc <= cyc + 1;

   // scoreboard state
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] tx_q[$];
   int n_tok, n_hs, n_ds, n_dv, n_de, n_ep, n_ec, n_el;
   logic [3:0]  cap_tok_pid, cap_tok_endp, cap_hs_pid, cap_dat_pid;
   logic [6:0]  cap_tok_addr;
   logic [10:0] cap_len;
   logic        cap_ok;
   int tok_cyc, fall_cyc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      n_tok = 0; n_hs = 0; n_ds = 0; n_dv = 0;
      n_de = 0; n_ep = 0; n_ec = 0; n_el = 0;
      cap_tok_pid = '0; cap_tok_endp = '0; cap_tok_addr = '0;
      cap_hs_pid = '0; cap_dat_pid = '0; cap_len = '0; cap_ok = 1'b0;
      tok_cyc = -1;
   endtask

   // monitor: sampled on the falling edge, away from the active edge
   always @(negedge phy_clk) begin
      if (reset_n) begin
         if (tok_valid) begin
            n_tok++; cap_tok_pid = tok_pid; cap_tok_addr = tok_addr;
            cap_tok_endp = tok_endp; tok_cyc = cyc;
         end
         if (hs_valid)  begin n_hs++; cap_hs_pid = hs_pid; end
         if (dat_start) begin n_ds++; cap_dat_pid = dat_pid; end
         if (dat_end)   begin n_de++; cap_len = dat_len; cap_ok = dat_crc_ok; end
         if (err_pid) n_ep++;
         if (err_crc) n_ec++;
         if (err_len) n_el++;
         if (dat_valid) begin
            n_dv++;
            if (exp_q.size() > 0) check_eq("dat_byte", {24'b0, dat_byte}, {24'b0, exp_q.pop_front()});
            else                  check_eq("dat_unexpected", exp_q.size(), 1);
         end
      end
   end

   // driver: one packet from tx_q, with 'gap' idle cycles after every byte
   task automatic send_pkt(input int gap);
      clear_counts();
      @(negedge phy_clk); in_act = 1'b1; in_latch = 1'b0;
      foreach (tx_q[i]) begin
         @(negedge phy_clk); in_latch = 1'b1; in_byte = tx_q[i];
         for (int g = 0; g < gap; g++) begin
            @(negedge phy_clk); in_latch = 1'b0; in_byte = 8'hFF;
         end
      end
      @(negedge phy_clk); in_latch = 1'b0; in_act = 1'b0; fall_cyc = cyc;
      repeat (4) @(negedge phy_clk);
   endtask

   task automatic expect_counts(input int tok, input int hs, input int ds, input int dv,
                                input int de, input int ep, input int ec, input int el);
      check_eq("n_tok_valid", n_tok, tok);
      check_eq("n_hs_valid",  n_hs,  hs);
      check_eq("n_dat_start", n_ds,  ds);
      check_eq("n_dat_valid", n_dv,  dv);
      check_eq("n_dat_end",   n_de,  de);
      check_eq("n_err_pid",   n_ep,  ep);
      check_eq("n_err_crc",   n_ec,  ec);
      check_eq("n_err_len",   n_el,  el);
      check_eq("exp_q_left",  exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_tok"}, {5'b0, tok_valid, tok_pid, tok_addr, tok_endp, tok_frame}, 0);
      check_eq({tag, "_hs"},  {27'b0, hs_valid, hs_pid}, 0);
      check_eq({tag, "_dat"}, {5'b0, dat_start, dat_pid, dat_valid, dat_byte, dat_end,
                               dat_crc_ok, dat_len}, 0);
      check_eq({tag, "_err"}, {29'b0, err_pid, err_crc, err_len}, 0);
      check_eq({tag, "_state"}, {29'b0, fsm_state}, 0);
   endtask

   initial begin
      reset_n = 1'b0; in_act = 1'b0; in_latch = 1'b0; in_byte = 8'h00;
      clear_counts();
      repeat (3) @(negedge phy_clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge phy_clk);

      // SETUP token, addr 0 endp 0
      tx_q = '{8'h2D, 8'h00, 8'h10};
      send_pkt(0);
      expect_counts(1, 0, 0, 0, 0, 0, 0, 0);
      check_eq("setup_pid", cap_tok_pid, 4'hD);
      check_eq("setup_addr", cap_tok_addr, 7'h00);
      check_eq("setup_endp", cap_tok_endp, 4'h0);
      check_eq("setup_latency", tok_cyc - fall_cyc, 1);

      // ACK handshake
      tx_q = '{8'hD2};
      send_pkt(0);
      expect_counts(0, 1, 0, 0, 0, 0, 0, 0);
      check_eq("ack_pid", cap_hs_pid, 4'h2);

      // bad PID check nibble
      tx_q = '{8'h2E, 8'h00, 8'h10};
      send_pkt(0);
      expect_counts(0, 0, 0, 0, 0, 1, 0, 0);

      // DATA0 GET_DESCRIPTOR setup payload, good CRC, latch gaps between bytes
      tx_q  = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
      exp_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      send_pkt(1);
      expect_counts(0, 0, 1, 8, 1, 0, 0, 0);
      check_eq("d0_pid", cap_dat_pid, 4'h3);
      check_eq("d0_len", cap_len, 11'd8);
      check_eq("d0_crc_ok", cap_ok, 1'b1);

      // same packet, corrupted CRC
      tx_q  = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
      exp_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      send_pkt(0);
      expect_counts(0, 0, 1, 8, 1, 0, 1, 0);
      check_eq("d0bad_len", cap_len, 11'd8);
      check_eq("d0bad_crc_ok", cap_ok, 1'b0);

      // zero-length DATA1
      tx_q = '{8'h4B, 8'h00, 8'h00};
      send_pkt(0);
      expect_counts(0, 0, 1, 0, 1, 0, 0, 0);
      check_eq("zlp_pid", cap_dat_pid, 4'hB);
      check_eq("zlp_len", cap_len, 11'd0);
      check_eq("zlp_crc_ok", cap_ok, 1'b1);

      // DATA1 too short
      tx_q = '{8'h4B, 8'h00};
      send_pkt(0);
      expect_counts(0, 0, 1, 0, 1, 0, 0, 1);
      check_eq("short_len", cap_len, 11'd0);
      check_eq("short_crc_ok", cap_ok, 1'b0);

      // token too short
      tx_q = '{8'h2D, 8'h00};
      send_pkt(0);
      expect_counts(0, 0, 0, 0, 0, 0, 0, 1);

      // token with bad CRC5
      tx_q = '{8'h2D, 8'h00, 8'h11};
      send_pkt(0);
      expect_counts(0, 0, 0, 0, 0, 0, 1, 0);

      // handshake with an extra byte
      tx_q = '{8'hD2, 8'h00};
      send_pkt(0);
      expect_counts(0, 0, 0, 0, 0, 0, 0, 1);

      // 9 payload bytes with MAX_DATA=8: only 8 forwarded, length error wins
      tx_q  = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                8'hAA, 8'hBB};
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_pkt(0);
      expect_counts(0, 0, 1, 8, 1, 0, 0, 1);
      check_eq("ovf_len", cap_len, 11'd9);
      check_eq("ovf_crc_ok", cap_ok, 1'b0);

      // two handshakes, the second starting in the cycle after in_act drops
      clear_counts();
      @(negedge phy_clk); in_act = 1'b1;
      @(negedge phy_clk); in_latch = 1'b1; in_byte = 8'hD2;
      @(negedge phy_clk); in_latch = 1'b0; in_act = 1'b0;
      @(negedge phy_clk); in_latch = 1'b1; in_act = 1'b1; in_byte = 8'h5A;
      @(negedge phy_clk); in_latch = 1'b0; in_act = 1'b0;
      repeat (4) @(negedge phy_clk);
      expect_counts(0, 2, 0, 0, 0, 0, 0, 0);
      check_eq("b2b_pid", cap_hs_pid, 4'hA);

      // reset in the middle of DATA0, released while in_act is still high
      clear_counts();
      exp_q = '{8'h80, 8'h06};
      @(negedge phy_clk); in_act = 1'b1;
      tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01};
      foreach (tx_q[i]) begin
         @(negedge phy_clk); in_latch = 1'b1; in_byte = tx_q[i];
      end
      @(negedge phy_clk); in_latch = 1'b0;
      check_eq("pre_rst_dat_start", n_ds, 1);
      #2 reset_n = 1'b0;
      #1 check_all_zero("mid_reset");
      @(negedge phy_clk); in_latch = 1'b1; in_byte = 8'h00;
      @(negedge phy_clk); reset_n = 1'b1; clear_counts(); exp_q.delete();
      in_latch = 1'b1; in_byte = 8'h00;
      @(negedge phy_clk); in_latch = 1'b1; in_byte = 8'h40;
      @(negedge phy_clk); in_latch = 1'b1; in_byte = 8'h00;
      @(negedge phy_clk); in_latch = 1'b0; in_act = 1'b0;
      repeat (4) @(negedge phy_clk);
      expect_counts(0, 0, 0, 0, 0, 0, 0, 0);
      tx_q = '{8'hD2};
      send_pkt(0);
      expect_counts(0, 1, 0, 0, 0, 0, 0, 0);
      check_eq("post_rst_hs_pid", cap_hs_pid, 4'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
